// File: rtl/uart_ser_param_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Package : uart_pkg                                                     |
// | Shared UART types and constants for the TX serializer and RX checker.  |
// | Revision: 1.0 - initial release                                        |
// +------------------------------------------------------------------------+
package uart_pkg;

    typedef enum logic [0:0] {
        SER_IDLE  = 1'b0,
        SER_SHIFT = 1'b1
    } ser_state_e;

    localparam logic PAR_EVEN    = 1'b0;
    localparam logic PAR_ODD     = 1'b1;

    localparam int   UART_DW_MIN = 5;
    localparam int   UART_DW_MAX = 9;

endpackage : uart_pkg
`default_nettype wire

// File: rtl/uart_ser_param_if.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Interface : uart_ser_param_if                                          |
// | TX FSM <-> serializer bundle; parity signals exist with                |
// | UART_SER_PARITY_EN defined.                                            |
// | Revision  : 1.0 - initial release                                      |
// +------------------------------------------------------------------------+
interface uart_ser_param_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] P_DATA;
    logic                  DATA_VALID;
    logic                  busy;
    logic                  ser_en;
    logic                  ser_data;
    logic                  ser_done;
    logic                  data_loaded;
`ifdef UART_SER_PARITY_EN
    logic                  PAR_TYP;
    logic                  par_bit;
`endif

    modport master (
        output P_DATA,
        output DATA_VALID,
        output busy,
        output ser_en,
`ifdef UART_SER_PARITY_EN
        output PAR_TYP,
        input  par_bit,
`endif
        input  ser_data,
        input  ser_done,
        input  data_loaded
    );

    modport slave (
        input  P_DATA,
        input  DATA_VALID,
        input  busy,
        input  ser_en,
`ifdef UART_SER_PARITY_EN
        input  PAR_TYP,
        output par_bit,
`endif
        output ser_data,
        output ser_done,
        output data_loaded
    );

endinterface : uart_ser_param_if
`default_nettype wire

// File: rtl/uart_parity_calc.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : uart_parity_calc                                             |
// | Combinational parity of a data word; PAR_TYP selects even/odd.         |
// | Revision: 1.0 - initial release                                        |
// +------------------------------------------------------------------------+
module uart_parity_calc
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_par_typ,
    output logic                  o_par_bit
);

    assign o_par_bit = (^i_data) ^ i_par_typ;

endmodule : uart_parity_calc
`default_nettype wire

// File: rtl/uart_ser_param.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : uart_ser_param                                               |
// | UART TX serializer with bit-order select and ser_en pause/resume.      |
// | Optional parity capture enabled by macro UART_SER_PARITY_EN.           |
// | Revision: 1.0 - initial release                                        |
// +------------------------------------------------------------------------+
module uart_ser_param
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int LSB_FIRST  = 1
) (
    input  logic            CLK,
    input  logic            RST,
    uart_ser_param_if.slave ser_if
);

    localparam int                 c_CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(DATA_WIDTH - 1);

    generate
        if (DATA_WIDTH < UART_DW_MIN || DATA_WIDTH > UART_DW_MAX) begin : g_dw_check
            $error("uart_ser_param: DATA_WIDTH out of range");
        end
    endgenerate

    ser_state_e              r_state;
    ser_state_e              w_state_nxt;
    logic [DATA_WIDTH-1:0]   r_shadow;
    logic [DATA_WIDTH-1:0]   w_shadow_nxt;
    logic [c_CNT_W-1:0]      r_cnt;
    logic [c_CNT_W-1:0]      w_cnt_nxt;
    logic [c_CNT_W-1:0]      w_bit_idx;
    logic                    r_ser_data;
    logic                    w_ser_data_nxt;
    logic                    r_ser_done;
    logic                    w_ser_done_nxt;
    logic                    r_loaded;
    logic                    w_loaded_nxt;
    logic                    w_load;

    // ser_en must be low on the load cycle so a stale enable cannot shift bit 0 early
    assign w_load    = (r_state == SER_IDLE) && ser_if.DATA_VALID && !ser_if.busy && !ser_if.ser_en;
    assign w_bit_idx = (LSB_FIRST != 0) ? r_cnt : (c_LAST - r_cnt);

    always_comb begin
        w_state_nxt    = r_state;
        w_shadow_nxt   = r_shadow;
        w_cnt_nxt      = r_cnt;
        w_ser_data_nxt = r_ser_data;
        w_ser_done_nxt = 1'b0;
        w_loaded_nxt   = r_loaded;
        case (r_state)
            SER_IDLE: begin
                w_ser_data_nxt = 1'b1;
                if (w_load) begin
                    w_shadow_nxt = ser_if.P_DATA;
                    w_cnt_nxt    = '0;
                    w_loaded_nxt = 1'b1;
                    w_state_nxt  = SER_SHIFT;
                end
            end
            SER_SHIFT: begin
                if (ser_if.ser_en) begin
                    w_ser_data_nxt = r_shadow[w_bit_idx];
                    if (r_cnt == c_LAST) begin
                        w_ser_done_nxt = 1'b1;
                        w_cnt_nxt      = '0;
                        w_loaded_nxt   = 1'b0;
                        w_state_nxt    = SER_IDLE;
                    end else begin
                        w_cnt_nxt = r_cnt + c_CNT_W'(1);
                    end
                end
            end
            default: begin
                w_state_nxt = SER_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_state    <= SER_IDLE;
            r_shadow   <= '0;
            r_cnt      <= '0;
            r_ser_data <= 1'b1;
            r_ser_done <= 1'b0;
            r_loaded   <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_shadow   <= w_shadow_nxt;
            r_cnt      <= w_cnt_nxt;
            r_ser_data <= w_ser_data_nxt;
            r_ser_done <= w_ser_done_nxt;
            r_loaded   <= w_loaded_nxt;
        end
    end

    assign ser_if.ser_data    = r_ser_data;
    assign ser_if.ser_done    = r_ser_done;
    assign ser_if.data_loaded = r_loaded;

`ifdef UART_SER_PARITY_EN
    logic w_par_calc;
    logic r_par_bit;

    uart_parity_calc #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_parity_calc (
        .i_data    (ser_if.P_DATA),
        .i_par_typ (ser_if.PAR_TYP),
        .o_par_bit (w_par_calc)
    );

    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_par_bit <= 1'b0;
        end else if (w_load) begin
            r_par_bit <= w_par_calc;
        end
    end

    assign ser_if.par_bit = r_par_bit;
`endif

endmodule : uart_ser_param
`default_nettype wire

// File: tb/tb_uart_ser_param.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : tb_uart_ser_param                                            |
// | Scoreboard bench: 8-bit LSB-first, 8-bit MSB-first and 5-bit DUTs.     |
// | Revision: 1.0 - initial release                                        |
// +------------------------------------------------------------------------+
module tb_uart_ser_param;
    import uart_pkg::*;

    logic CLK = 1'b0;
    logic RST;
    always #5 CLK = ~CLK;

    uart_ser_param_if #(.DATA_WIDTH(8)) if_a ();
    uart_ser_param_if #(.DATA_WIDTH(8)) if_m ();
    uart_ser_param_if #(.DATA_WIDTH(5)) if_b ();

    uart_ser_param #(.DATA_WIDTH(8), .LSB_FIRST(1)) dut_a (.CLK(CLK), .RST(RST), .ser_if(if_a.slave));
    uart_ser_param #(.DATA_WIDTH(8), .LSB_FIRST(0)) dut_m (.CLK(CLK), .RST(RST), .ser_if(if_m.slave));
    uart_ser_param #(.DATA_WIDTH(5), .LSB_FIRST(1)) dut_b (.CLK(CLK), .RST(RST), .ser_if(if_b.slave));

    int   errors = 0;
    int   checks = 0;
    logic exp_q[$];

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // sel: 0 = 8-bit LSB-first, 1 = 8-bit MSB-first, 2 = 5-bit LSB-first
    task automatic drive(input int sel, input logic [8:0] d, input logic v, input logic b, input logic e);
        case (sel)
            0: begin if_a.P_DATA = d[7:0]; if_a.DATA_VALID = v; if_a.busy = b; if_a.ser_en = e; end
            1: begin if_m.P_DATA = d[7:0]; if_m.DATA_VALID = v; if_m.busy = b; if_m.ser_en = e; end
            default: begin if_b.P_DATA = d[4:0]; if_b.DATA_VALID = v; if_b.busy = b; if_b.ser_en = e; end
        endcase
    endtask

    // {ser_data, ser_done, data_loaded}
    function automatic logic [2:0] obs(input int sel);
        case (sel)
            0:       return {if_a.ser_data, if_a.ser_done, if_a.data_loaded};
            1:       return {if_m.ser_data, if_m.ser_done, if_m.data_loaded};
            default: return {if_b.ser_data, if_b.ser_done, if_b.data_loaded};
        endcase
    endfunction

    task automatic push_expected(input logic [8:0] w, input int width, input bit lsb);
        for (int k = 0; k < width; k++) begin
            exp_q.push_back(lsb ? w[k] : w[width-1-k]);
        end
    endtask

    task automatic test_reset();
        RST = 1'b0;
        for (int s = 0; s < 3; s++) drive(s, 9'h0, 1'b0, 1'b0, 1'b0);
`ifdef UART_SER_PARITY_EN
        if_a.PAR_TYP = PAR_EVEN; if_m.PAR_TYP = PAR_EVEN; if_b.PAR_TYP = PAR_EVEN;
`endif
        tick(); tick();
        for (int s = 0; s < 3; s++) begin
            checks++;
            if (obs(s) !== 3'b100) begin
                errors++;
                $display("FAIL reset_dut%0d: got %b expected 100", s, obs(s));
            end
        end
`ifdef UART_SER_PARITY_EN
        checks++;
        if (if_a.par_bit !== 1'b0) begin
            errors++;
            $display("FAIL reset_par_bit: got %b expected 0", if_a.par_bit);
        end
`endif
        RST = 1'b1;
        drive(0, 9'h0, 1'b0, 1'b0, 1'b1);
        tick();
        drive(0, 9'h0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (obs(0) !== 3'b100) begin
            errors++;
            $display("FAIL idle_ser_en_ignored: got %b expected 100", obs(0));
        end
    endtask

    task automatic test_bit_order(input int sel);
        logic e;
        drive(sel, 9'h035, 1'b1, 1'b0, 1'b0);
        tick();
        drive(sel, 9'h0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (obs(sel) !== 3'b101) begin
            errors++;
            $display("FAIL order%0d_load: got %b expected 101", sel, obs(sel));
        end
        push_expected(9'h035, 8, sel == 0);
        for (int k = 0; k < 8; k++) begin
            drive(sel, 9'h0, 1'b0, 1'b0, 1'b1);
            tick();
            e = exp_q.pop_front();
            checks++;
            if (obs(sel) !== {e, (k == 7), (k != 7)}) begin
                errors++;
                $display("FAIL order%0d_bit%0d: got %b expected %b", sel, k, obs(sel), {e, (k == 7), (k != 7)});
            end
        end
        drive(sel, 9'h0, 1'b0, 1'b0, 1'b0);
        tick();
        checks++;
        if (obs(sel) !== 3'b100) begin
            errors++;
            $display("FAIL order%0d_done_clear: got %b expected 100", sel, obs(sel));
        end
    endtask

    task automatic test_pause();
        logic e;
        drive(2, 9'h013, 1'b1, 1'b0, 1'b0);
        tick();
        drive(2, 9'h0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (obs(2) !== 3'b101) begin
            errors++;
            $display("FAIL pause_load: got %b expected 101", obs(2));
        end
        push_expected(9'h013, 5, 1'b1);
        for (int k = 0; k < 5; k++) begin
            drive(2, 9'h0, 1'b0, 1'b0, 1'b1);
            tick();
            e = exp_q.pop_front();
            checks++;
            if (obs(2) !== {e, (k == 4), (k != 4)}) begin
                errors++;
                $display("FAIL pause_bit%0d: got %b expected %b", k, obs(2), {e, (k == 4), (k != 4)});
            end
            if (k == 2) begin
                for (int p = 0; p < 3; p++) begin
                    drive(2, 9'h0, 1'b0, 1'b0, 1'b0);
                    tick();
                    checks++;
                    if (obs(2) !== {e, 1'b0, 1'b1}) begin
                        errors++;
                        $display("FAIL pause_hold%0d: got %b expected %b", p, obs(2), {e, 1'b0, 1'b1});
                    end
                end
            end
        end
        drive(2, 9'h0, 1'b0, 1'b0, 1'b0);
        tick();
        checks++;
        if (obs(2) !== 3'b100) begin
            errors++;
            $display("FAIL pause_done_clear: got %b expected 100", obs(2));
        end
    endtask

    task automatic test_ignore_reload();
        logic e;
        drive(0, 9'h035, 1'b1, 1'b0, 1'b0);
        tick();
        push_expected(9'h035, 8, 1'b1);
        for (int k = 0; k < 8; k++) begin
            if (k == 3) begin
                drive(0, 9'h0FF, 1'b1, 1'b0, 1'b0);
                tick();
                checks++;
                if (obs(0) !== {e, 1'b0, 1'b1}) begin
                    errors++;
                    $display("FAIL reload_hold: got %b expected %b", obs(0), {e, 1'b0, 1'b1});
                end
            end
            drive(0, 9'h0FF, (k == 5), 1'b0, 1'b1);
            tick();
            e = exp_q.pop_front();
            checks++;
            if (obs(0) !== {e, (k == 7), (k != 7)}) begin
                errors++;
                $display("FAIL reload_bit%0d: got %b expected %b", k, obs(0), {e, (k == 7), (k != 7)});
            end
        end
        drive(0, 9'h0FF, 1'b1, 1'b1, 1'b0);
        tick();
        checks++;
        if (obs(0) !== 3'b100) begin
            errors++;
            $display("FAIL busy_refused: got %b expected 100", obs(0));
        end
        drive(0, 9'h0FF, 1'b1, 1'b0, 1'b1);
        tick();
        checks++;
        if (obs(0) !== 3'b100) begin
            errors++;
            $display("FAIL ser_en_refused: got %b expected 100", obs(0));
        end
        drive(0, 9'h0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        logic e;
        drive(0, 9'h035, 1'b1, 1'b0, 1'b0);
        tick();
        push_expected(9'h035, 8, 1'b1);
        push_expected(9'h0C3, 8, 1'b1);
        for (int f = 0; f < 2; f++) begin
            for (int k = 0; k < 8; k++) begin
                drive(0, 9'h0, 1'b0, 1'b0, 1'b1);
                tick();
                e = exp_q.pop_front();
                checks++;
                if (obs(0) !== {e, (k == 7), (k != 7)}) begin
                    errors++;
                    $display("FAIL b2b_f%0d_bit%0d: got %b expected %b", f, k, obs(0), {e, (k == 7), (k != 7)});
                end
            end
            drive(0, 9'h0C3, (f == 0), 1'b0, 1'b0);
            tick();
            drive(0, 9'h0, 1'b0, 1'b0, 1'b0);
            checks++;
            if (obs(0) !== {1'b1, 1'b0, (f == 0)}) begin
                errors++;
                $display("FAIL b2b_reload%0d: got %b expected %b", f, obs(0), {1'b1, 1'b0, (f == 0)});
            end
        end
    endtask

    task automatic test_reset_mid();
        logic e;
        drive(0, 9'h035, 1'b1, 1'b0, 1'b0);
        tick();
        push_expected(9'h035, 8, 1'b1);
        for (int k = 0; k < 4; k++) begin
            drive(0, 9'h0, 1'b0, 1'b0, 1'b1);
            tick();
            e = exp_q.pop_front();
            checks++;
            if (obs(0) !== {e, 1'b0, 1'b1}) begin
                errors++;
                $display("FAIL rstmid_bit%0d: got %b expected %b", k, obs(0), {e, 1'b0, 1'b1});
            end
        end
        RST = 1'b0;
        tick();
        RST = 1'b1;
        exp_q.delete();
        checks++;
        if (obs(0) !== 3'b100) begin
            errors++;
            $display("FAIL rstmid_abort: got %b expected 100", obs(0));
        end
        for (int k = 0; k < 4; k++) begin
            tick();
            checks++;
            if (obs(0) !== 3'b100) begin
                errors++;
                $display("FAIL rstmid_no_done%0d: got %b expected 100", k, obs(0));
            end
        end
        drive(0, 9'h0A5, 1'b1, 1'b0, 1'b0);
        tick();
        push_expected(9'h0A5, 8, 1'b1);
        for (int k = 0; k < 8; k++) begin
            drive(0, 9'h0, 1'b0, 1'b0, 1'b1);
            tick();
            e = exp_q.pop_front();
            checks++;
            if (obs(0) !== {e, (k == 7), (k != 7)}) begin
                errors++;
                $display("FAIL rstmid_a5_bit%0d: got %b expected %b", k, obs(0), {e, (k == 7), (k != 7)});
            end
        end
        drive(0, 9'h0, 1'b0, 1'b0, 1'b0);
        tick();
    endtask

`ifdef UART_SER_PARITY_EN
    task automatic test_parity();
        logic [7:0] words [3] = '{8'h35, 8'h35, 8'h07};
        logic       types [3] = '{PAR_EVEN, PAR_ODD, PAR_EVEN};
        logic       expp  [3] = '{1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 3; i++) begin
            if_a.PAR_TYP = types[i];
            drive(0, {1'b0, words[i]}, 1'b1, 1'b0, 1'b0);
            tick();
            drive(0, 9'h0, 1'b0, 1'b0, 1'b0);
            if_a.PAR_TYP = ~types[i];
            checks++;
            if (if_a.par_bit !== expp[i]) begin
                errors++;
                $display("FAIL parity%0d_load: got %b expected %b", i, if_a.par_bit, expp[i]);
            end
            for (int k = 0; k < 8; k++) begin
                drive(0, 9'h0, 1'b0, 1'b0, 1'b1);
                tick();
            end
            drive(0, 9'h0, 1'b0, 1'b0, 1'b0);
            tick();
            checks++;
            if (if_a.par_bit !== expp[i]) begin
                errors++;
                $display("FAIL parity%0d_stable: got %b expected %b", i, if_a.par_bit, expp[i]);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_bit_order(0);
        test_bit_order(1);
        test_pause();
        test_ignore_reload();
        test_back_to_back();
        test_reset_mid();
`ifdef UART_SER_PARITY_EN
        test_parity();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_uart_ser_param
`default_nettype wire

// File: doc/uart_ser_param.md
# uart_ser_param

Parametrised UART transmit serializer: captures a DATA_WIDTH-bit parallel word from the TX front end and shifts it out one bit per enabled cycle under control of the UART TX FSM. It has configurable bit order and pause/resume on `ser_en`, and optionally computes a parity bit at load time. It sits between the TX FSM (`ser_en`, `busy`) and the output mux (`ser_data`, `par_bit`).

## Interface
- DATA_WIDTH, 8: frame payload width; legal range 5..9.
- LSB_FIRST, 1: 1 = bit 0 is sent first; 0 = bit DATA_WIDTH-1 is sent first.
- CLK  in  1: sole clock, rising edge.
- RST  in  1: synchronous, active-low reset.
- P_DATA  in  DATA_WIDTH: parallel word.
- DATA_VALID  in  1: P_DATA is valid this cycle.
- busy  in  1: TX FSM is mid-frame (start, parity or stop phase); blocks loading.
- ser_en  in  1: shift-enable from the TX FSM.
- PAR_TYP  in  1: 0 = even, 1 = odd. Present only with UART_SER_PARITY_EN.
- ser_data  out  1: serial bit.
- ser_done  out  1: one-cycle pulse marking the last payload bit.
- data_loaded  out  1: a word is held and not yet fully shifted.
- par_bit  out  1: parity of the held word. Present only with UART_SER_PARITY_EN.

## Operation
- Two states:
  - IDLE: no word held.
  - SHIFT: word held; shifting is in progress or paused.
- IDLE → SHIFT: `DATA_VALID && !busy && !ser_en`. P_DATA is captured into the shadow register, `bit_cnt` is set to 0 and `data_loaded` is set to 1.
- In IDLE:
  - `ser_en` without a held word is ignored.
  - `ser_data` is driven to 1 (line idle).
- In SHIFT with `ser_en = 1`:
  - `ser_data` ← shadow[`bit_cnt`] when LSB_FIRST = 1, else shadow[DATA_WIDTH-1-`bit_cnt`].
  - `bit_cnt` increments.
- In SHIFT with `ser_en = 0`: pause. `ser_data`, `bit_cnt` and the shadow register all hold.
- Last bit: when `ser_en = 1` and `bit_cnt` = DATA_WIDTH-1, the last bit is driven and, on the same edge:
  - `ser_done` ← 1
  - `bit_cnt` ← 0
  - `data_loaded` ← 0
  - state ← IDLE
- `ser_done` clears on the next edge; it is never high for two consecutive cycles.
- `DATA_VALID` while in SHIFT is ignored and the held word is never overwritten.
- Width of `bit_cnt` is $clog2(DATA_WIDTH). It never wraps past DATA_WIDTH-1.
- Reset values: `ser_data` = 1, `ser_done` = 0, `data_loaded` = 0, `par_bit` = 0, shadow = 0, `bit_cnt` = 0, state = IDLE.
- Reset asserted mid-frame: the frame is aborted and all of the reset values above apply on the next edge. No `ser_done` pulse is produced.

## Timing
- Load: `data_loaded` rises 1 cycle after the qualifying `DATA_VALID` cycle.
- Bit k appears on `ser_data` 1 cycle after the k-th `ser_en`-high cycle of the frame.
- An uninterrupted frame spans exactly DATA_WIDTH `ser_en` cycles. `ser_done` is high in the same cycle that `ser_data` shows the last bit.
- Back-to-back frames: a new load is accepted in the cycle `ser_done` is high, provided `busy` and `ser_en` are low.
- `par_bit` is valid 1 cycle after load and is stable until the next load.

## Configuration
- Macro: UART_SER_PARITY_EN.
- Defined:
  - `PAR_TYP` and `par_bit` ports exist.
  - On load, `par_bit` ← (^P_DATA) ^ PAR_TYP, registered alongside the shadow register.
- Undefined: the ports and logic are absent, and the shift behaviour is otherwise identical.

## Structure
- Shared package `uart_pkg`:
  - state enum (`SER_IDLE`, `SER_SHIFT`)
  - parity-type constants `PAR_EVEN` = 0, `PAR_ODD` = 1
  - `UART_DW_MIN` = 5, `UART_DW_MAX` = 9
- One sub-module, `uart_parity_calc`: a combinational reduction over DATA_WIDTH plus PAR_TYP. It is instantiated only under UART_SER_PARITY_EN and is reused by the RX checker.

## Test plan
- DATA_WIDTH = 8, LSB_FIRST = 1, load 0x35, then 8 consecutive `ser_en` cycles → `ser_data` = 1,0,1,0,1,1,0,0; `ser_done` high with the 8th bit only; `data_loaded` falls with it.
- LSB_FIRST = 0, load 0x35 → `ser_data` = 0,0,1,1,0,1,0,1.
- DATA_WIDTH = 5, load 0x13, with `ser_en` dropped for 3 cycles after bit 2 → `ser_data` = 1,1,0 (held for 3 cycles),0,1; `ser_done` after exactly 5 enabled cycles.
- Load 0x35, then `DATA_VALID` with P_DATA = 0xFF during SHIFT → output still 0x35; a second load attempted with `busy` = 1 is refused (`data_loaded` stays 0).
- UART_SER_PARITY_EN, load 0x35 → `par_bit` = 0 with PAR_TYP = 0, 1 with PAR_TYP = 1; load 0x07 with PAR_TYP = 0 → `par_bit` = 1.
- RST low after bit 3 → next cycle `ser_data` = 1, `ser_done` = 0, `data_loaded` = 0; no `ser_done` pulse; a fresh load of 0xA5 afterwards serializes correctly from bit 0.
